// File: rtl/screen_sequencer.sv
// Text screen sequencer: host writes, clear and scroll commands into a char buffer.
// Optional scroll-up support is enabled with `define SCREEN_SEQ_SCROLL_EN.
module screen_sequencer #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cmd,
  input  logic [ROW_BITS-1:0]  cmd_row,
  input  logic [COL_BITS-1:0]  cmd_col,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           host_char,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic                 host_wen,
  output logic                 host_ready,
  input  logic [ADDR_BITS-1:0] first_char,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic [ADDR_BITS-1:0] new_first_char,
  output logic                 new_first_char_wen,
  output logic                 done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCROLL = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;

  localparam logic [1:0] C_CLR = 2'd0;
  localparam logic [1:0] C_EOL = 2'd1;
  localparam logic [1:0] C_SCR = 2'd2;
  localparam logic [1:0] C_EOS = 2'd3;

  localparam int SW = ADDR_BITS + 2;
  localparam logic [SW-1:0] CELLS = SW'(ROWS * COLS);
  localparam logic [SW-1:0] NCOL  = SW'(COLS);
  localparam logic [SW-1:0] NROW  = SW'(ROWS);
  localparam logic [7:0]    BLANK = 8'h20;

`ifdef SCREEN_SEQ_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
`else
  localparam bit SCROLL_EN = 1'b0;
`endif

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           char_q, char_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wen_q, wen_d;
  logic [ADDR_BITS-1:0] nfc_q, nfc_d;
  logic                 nfcw_q, nfcw_d;
  logic                 done_q, done_d;

  logic [SW-1:0]        off, sum, wsum, scr, wscr, len;
  logic [ADDR_BITS-1:0] pos, st;
  logic                 bad;

  function automatic logic [ADDR_BITS-1:0] inc(
    input logic [ADDR_BITS-1:0] a
  );
    if (SW'(a) == CELLS - 1'b1) return '0;
    return a + 1'b1;
  endfunction

  // Sums never exceed two screens, so one conditional subtract wraps them.
  always_comb begin
    off  = SW'(cmd_row) * NCOL + SW'(cmd_col);
    sum  = SW'(first_char) + off;
    wsum = (sum >= CELLS) ? sum - CELLS : sum;
    pos  = ADDR_BITS'(wsum);
    scr  = SW'(first_char) + NCOL;
    wscr = (scr >= CELLS) ? scr - CELLS : scr;
    bad  = (SW'(cmd_row) >= NROW) || (SW'(cmd_col) >= NCOL);
    st   = (cmd == C_CLR) ? first_char : pos;
    case (cmd)
      C_CLR:   len = CELLS;
      C_EOL:   len = NCOL - SW'(cmd_col);
      C_EOS:   len = CELLS - off;
      default: len = NCOL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    char_d  = char_q;
    addr_d  = addr_q;
    wen_d   = 1'b0;
    nfc_d   = nfc_q;
    nfcw_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_wen) begin
          char_d = host_char;
          addr_d = host_addr;
          wen_d  = 1'b1;
        end
        if (cmd_valid) begin
          if (bad || (cmd == C_SCR && !SCROLL_EN)) begin
            done_d = 1'b1;
          end else if (cmd == C_SCR) begin
            // A same-cycle host write defers the scroll pulse one cycle.
            state_d = SCROLL;
            ptr_d   = first_char;
            nfc_d   = ADDR_BITS'(wscr);
            pend_d  = host_wen;
            nfcw_d  = !host_wen;
          end else if (host_wen) begin
            state_d = FILL;
            ptr_d   = st;
            cnt_d   = len;
          end else begin
            state_d = FILL;
            char_d  = BLANK;
            addr_d  = st;
            wen_d   = 1'b1;
            ptr_d   = inc(st);
            cnt_d   = len - 1'b1;
          end
        end
      end
      SCROLL: begin
        if (pend_q) begin
          nfcw_d = 1'b1;
          pend_d = 1'b0;
        end else begin
          state_d = FILL;
          char_d  = BLANK;
          addr_d  = ptr_q;
          wen_d   = 1'b1;
          ptr_d   = inc(ptr_q);
          cnt_d   = NCOL - 1'b1;
        end
      end
      FILL: begin
        if (cnt_q != '0) begin
          char_d = BLANK;
          addr_d = ptr_q;
          wen_d  = 1'b1;
          ptr_d  = inc(ptr_q);
          cnt_d  = cnt_q - 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      char_q  <= 8'h00;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      nfc_q   <= '0;
      nfcw_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      char_q  <= char_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      nfc_q   <= nfc_d;
      nfcw_q  <= nfcw_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready          = (state_q == IDLE);
  assign host_ready         = (state_q == IDLE);
  assign new_char           = char_q;
  assign new_char_address   = addr_q;
  assign new_char_wen       = wen_q;
  assign new_first_char     = nfc_q;
  assign new_first_char_wen = nfcw_q;
  assign done               = done_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: fills, wrap, scroll, bad args, reset.
// Scroll expectations follow `define SCREEN_SEQ_SCROLL_EN.
module tb_screen_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [4:0]  cmd_row;
  logic [6:0]  cmd_col;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  host_char;
  logic [10:0] host_addr;
  logic        host_wen;
  logic        host_ready;
  logic [10:0] first_char;
  logic [7:0]  new_char;
  logic [10:0] new_char_address;
  logic        new_char_wen;
  logic [10:0] new_first_char;
  logic        new_first_char_wen;
  logic        done;

  int passed = 0;
  int total  = 0;

  screen_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .cmd                (cmd),
    .cmd_row            (cmd_row),
    .cmd_col            (cmd_col),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .host_char          (host_char),
    .host_addr          (host_addr),
    .host_wen           (host_wen),
    .host_ready         (host_ready),
    .first_char         (first_char),
    .new_char           (new_char),
    .new_char_address   (new_char_address),
    .new_char_wen       (new_char_wen),
    .new_first_char     (new_first_char),
    .new_first_char_wen (new_first_char_wen),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present a command at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input int c, input int r, input int col,
                       input int fc, input bit hw, input int ha,
                       input int hc);
    cmd        = 2'(c);
    cmd_row    = 5'(r);
    cmd_col    = 7'(col);
    first_char = 11'(fc);
    host_wen   = hw;
    host_addr  = 11'(ha);
    host_char  = 8'(hc);
    cmd_valid  = 1'b1;
    chk("ready_before", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    host_wen  = 1'b0;
  endtask

  // Expects n blank writes from start, beginning at the current negedge.
  task automatic watch(input int n, input int start,
                       input bit noisy, input bit fin);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk("fill_wen", new_char_wen, 1);
      chk("fill_addr", new_char_address, (start + i) % 1920);
      chk("fill_done", done, 0);
      chk("fill_nfcw", new_first_char_wen, 0);
      if (i == 0) chk("fill_char", new_char, 32);
      if (i == 0) chk("busy", cmd_ready, 0);
      host_wen  = noisy && (i < n - 1);
      host_addr = 11'd3;
      host_char = 8'h55;
    end
    host_wen = 1'b0;
    if (fin) begin
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_wen", new_char_wen, 0);
      chk("done_ready", cmd_ready, 1);
      @(negedge clk);
      chk("done_end", done, 0);
    end
  endtask

  task automatic bad_cmd(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wen"}, new_char_wen, 0);
    chk({tag, "_nfcw"}, new_first_char_wen, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    @(negedge clk);
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_wen_end"}, new_char_wen, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cmd        = 2'd0;
    cmd_row    = '0;
    cmd_col    = '0;
    cmd_valid  = 1'b0;
    host_char  = '0;
    host_addr  = '0;
    host_wen   = 1'b0;
    first_char = '0;
    repeat (3) @(negedge clk);
    chk("rst_char", new_char, 0);
    chk("rst_addr", new_char_address, 0);
    chk("rst_wen", new_char_wen, 0);
    chk("rst_nfc", new_first_char, 0);
    chk("rst_nfcw", new_first_char_wen, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_hready", host_ready, 1);

    // Plain host write.
    issue(0, 31, 0, 0, 1, 1234, 8'h41);
    chk("hw_wen", new_char_wen, 1);
    chk("hw_addr", new_char_address, 1234);
    chk("hw_char", new_char, 8'h41);
    chk("hw_baddone", done, 1);
    @(negedge clk);
    chk("hw_wen_end", new_char_wen, 0);

    // Clear to end of line, row 0 col 0.
    issue(1, 0, 0, 0, 0, 0, 0);
    watch(80, 0, 0, 1);
    // Same with wrap through 1919.
    issue(1, 0, 0, 1900, 0, 0, 0);
    watch(80, 1900, 0, 1);
    // Partial line: row 3 col 75 -> 5 cells from 315.
    issue(1, 3, 75, 0, 0, 0, 0);
    watch(5, 315, 0, 1);
    // Last column only: one cell.
    issue(1, 0, 79, 100, 0, 0, 0);
    watch(1, 179, 0, 1);
    // Clear to end of screen near the bottom.
    issue(3, 23, 70, 0, 0, 0, 0);
    watch(10, 1910, 0, 1);
    // Out-of-range arguments.
    issue(3, 24, 0, 0, 0, 0, 0);
    bad_cmd("row24");
    issue(1, 0, 80, 0, 0, 0, 0);
    bad_cmd("col80");

`ifdef SCREEN_SEQ_SCROLL_EN
    issue(2, 0, 0, 0, 0, 0, 0);
    chk("scr_nfcw", new_first_char_wen, 1);
    chk("scr_nfc", new_first_char, 80);
    chk("scr_wen", new_char_wen, 0);
    @(negedge clk);
    watch(80, 0, 0, 1);
    issue(2, 0, 0, 1880, 0, 0, 0);
    chk("scrw_nfcw", new_first_char_wen, 1);
    chk("scrw_nfc", new_first_char, 40);
    @(negedge clk);
    watch(80, 1880, 0, 1);
`else
    issue(2, 0, 0, 0, 0, 0, 0);
    bad_cmd("scr_off");
    chk("scr_off_nfc", new_first_char, 0);
`endif

    // Clear screen with a same-cycle host write and host noise during fill.
    issue(0, 0, 0, 7, 1, 5, 8'h41);
    chk("clr_hw_wen", new_char_wen, 1);
    chk("clr_hw_addr", new_char_address, 5);
    chk("clr_hw_char", new_char, 8'h41);
    chk("clr_hw_done", done, 0);
    @(negedge clk);
    watch(1920, 7, 1, 1);
    chk("clr_nfc", new_first_char, 0);

    // Reset after the 100th fill write.
    issue(0, 0, 0, 0, 0, 0, 0);
    watch(100, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_wen", new_char_wen, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", new_char_address, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_nodone", done, 0);
      chk("mid_rst_nowen", new_char_wen, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 24, text rows on screen.
REQ-002 SHALL have parameter COLS, default 80, text columns per row.
REQ-003 SHALL have parameter ROW_BITS, default 5; COL_BITS, default 7; ADDR_BITS, default 11; widths of row, column and char buffer address.
REQ-004 SHALL have ports:
clk  input  1  sole clock; one clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd  input  2  0=clear screen, 1=clear to end of line, 2=scroll up one line, 3=clear to end of screen
cmd_row  input  ROW_BITS  logical row argument
cmd_col  input  COL_BITS  column argument
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when high with cmd_valid
host_char  input  8  direct character write data
host_addr  input  ADDR_BITS  direct physical write address
host_wen  input  1  direct write strobe
host_ready  output  1  direct writes honoured only when high
first_char  input  ADDR_BITS  current scroll register value
new_char  output  8  char buffer write data
new_char_address  output  ADDR_BITS  char buffer write address
new_char_wen  output  1  char buffer write enable
new_first_char  output  ADDR_BITS  new scroll value
new_first_char_wen  output  1  scroll register write pulse
done  output  1  one-cycle pulse at command completion

Function
REQ-005 SHALL use states IDLE, SCROLL, FILL; cmd_ready = host_ready = (state==IDLE).
REQ-006 SHALL, in IDLE with host_wen, drive new_char/new_char_address/new_char_wen from host_char/host_addr on the next cycle (1-cycle registered latency); host_wen outside IDLE SHALL be ignored.
REQ-007 SHALL, in IDLE, accept a command on cmd_valid; simultaneous host_wen and cmd_valid SHALL both be honoured (host write occupies cycle T+1, fill starts T+2).
REQ-008 SHALL compute physical addresses modulo ROWS*COLS (1920): addr = (first_char + row*COLS + col) mod 1920; increments from 1919 SHALL wrap to 0.
REQ-009 SHALL write fill character 0x20 once per cycle in FILL, count decrementing to zero, then pulse done and return to IDLE on the same cycle.
REQ-010 Clear screen SHALL write 1920 cells starting at address first_char and SHALL NOT modify the scroll register.
REQ-011 Clear to end of line SHALL write COLS-cmd_col cells starting at (cmd_row, cmd_col).
REQ-012 Clear to end of screen SHALL write ROWS*COLS-(cmd_row*COLS+cmd_col) cells starting at (cmd_row, cmd_col).
REQ-013 Scroll up SHALL enter SCROLL, pulse new_first_char_wen for one cycle with new_first_char = (first_char+COLS) mod 1920, then FILL COLS cells starting at the old first_char (the new bottom line).
REQ-014 Without a host write in the acceptance cycle, the first fill write SHALL occur at T+1 (T = acceptance cycle), or scroll pulse at T+1 and first fill write at T+2; done SHALL assert the cycle after the last write.
REQ-015 cmd_row>=ROWS or cmd_col>=COLS SHALL perform no writes and pulse done at T+1.
REQ-016 new_char_wen and new_first_char_wen SHALL never assert together.

Reset
REQ-017 reset SHALL force IDLE, new_char=0x00, new_char_address=0, new_char_wen=0, new_first_char=0, new_first_char_wen=0, done=0 on the next edge.
REQ-018 reset mid-command SHALL abandon remaining writes with no done pulse; cmd_ready high the cycle after reset deasserts.

Configuration
REQ-019 With SCREEN_SEQ_SCROLL_EN defined, cmd 2 SHALL behave per REQ-013; without it, cmd 2 SHALL perform no writes, never pulse new_first_char_wen, and pulse done at T+1.

Verification
REQ-020 first_char=0, cmd=1 row=0 col=0 -> 80 writes of 0x20 to addresses 0..79 at T+1..T+80, done at T+81.
REQ-021 first_char=1900, cmd=1 row=0 col=0 -> addresses 1900..1919 then 0..59, wrap verified, done after 80 writes.
REQ-022 first_char=0, cmd=2 (macro defined) -> new_first_char=80 pulse at T+1, writes to 0..79 at T+2..T+81; macro undefined -> no writes, done at T+1.
REQ-023 cmd=3 row=23 col=70 -> 10 writes at addresses 1910..1919; cmd row=24 -> zero writes, done at T+1.
REQ-024 cmd=0 with host_wen addr=5 same cycle -> host write at T+1, 1920 fills after; host_wen during fill ignored; reset at fill write 100 -> wen low next cycle, no done.
